// File: rtl/gpu_frame_ctrl.sv
// gpu_frame_ctrl: per-frame sequencer for one GPU_top render pass.
// Uploads vertex words into GPU vertex memory, pulses start, waits for
// frame_end and for the AXI writer to drain. On display vsync it swaps the
// front and back framebuffer base addresses.
module gpu_frame_ctrl #(
  parameter int          M                = 11,
  parameter int          N                = 7,
  parameter int          VERTEX_MEM_DEPTH = 16384,
  parameter logic [31:0] FB_BASE0         = 32'h1000_0000,
  parameter logic [31:0] FB_BASE1         = 32'h1008_0000,
  parameter int          TIMEOUT_CYCLES   = 2000000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [31:0]                         cfg_vertex_count,
  input  logic                                cfg_auto,
  input  logic                                cmd_load,
  input  logic                                cmd_run,
  input  logic                                cmd_abort,
  input  logic [M+N-1:0]                      s_vtx_data,
  input  logic                                s_vtx_valid,
  output logic                                s_vtx_ready,
  output logic [$clog2(VERTEX_MEM_DEPTH)-1:0] mem_wr_addr,
  output logic [M+N-1:0]                      mem_wr_data,
  output logic                                mem_wr_en,
  output logic [31:0]                         vertex_count,
  output logic                                gpu_start,
  input  logic                                gpu_frame_end,
  input  logic                                wr_idle,
  input  logic                                vsync,
  output logic [31:0]                         framebuffer_baseaddr,
  output logic [31:0]                         display_baseaddr,
  output logic                                busy,
  output logic                                loaded,
  output logic                                frame_done,
  output logic [15:0]                         frame_counter,
  output logic                                err_count,
  output logic                                err_timeout
);

  localparam int AW = $clog2(VERTEX_MEM_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_RENDER, ST_DRAIN, ST_SWAP_WAIT
  } state_e;

  state_e          state_q;
  logic [1:0]      rst_sync_q;
  logic            rst_n;
  logic [31:0]     vertex_count_q;
  logic [AW:0]     idx_q;
  logic [TW-1:0]   tmo_q;
  logic            fe_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [M+N-1:0]  wr_data_q;
  logic            loaded_q;
  logic            err_count_q;
  logic            err_timeout_q;
  logic [31:0]     fb_q;
  logic [31:0]     disp_q;
  logic            frame_done_q;
  logic [15:0]     frame_counter_q;

  logic cnt_ok, last_hs, fe_rise;

  // Reset asserts asynchronously, releases two clocks after the pin goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign cnt_ok  = (cfg_vertex_count != 32'd0) &&
                   (cfg_vertex_count <= 32'(VERTEX_MEM_DEPTH));
  assign last_hs = ((32'(idx_q) + 32'd1) == vertex_count_q);
  assign fe_rise = gpu_frame_end & ~fe_q;

  // Previous frame_end level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fe_q <= 1'b0;
    else        fe_q <= gpu_frame_end;
  end

  // Frame sequencer: upload, start, render, drain, swap on vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      vertex_count_q  <= '0;
      idx_q           <= '0;
      tmo_q           <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      loaded_q        <= 1'b0;
      err_count_q     <= 1'b0;
      err_timeout_q   <= 1'b0;
      fb_q            <= FB_BASE1;
      disp_q          <= FB_BASE0;
      frame_done_q    <= 1'b0;
      frame_counter_q <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (cmd_abort) begin
        // Abort beats everything; a handshake in this cycle is not written.
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_load) begin
              if (cnt_ok) begin
                vertex_count_q <= cfg_vertex_count;
                loaded_q       <= 1'b0;
                err_count_q    <= 1'b0;
                idx_q          <= '0;
                state_q        <= ST_LOAD;
              end else begin
                err_count_q <= 1'b1;
              end
            end else if (cmd_run && loaded_q) begin
              state_q <= ST_START;
            end
          end
          ST_LOAD: begin
            if (s_vtx_valid) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= idx_q[AW-1:0];
              wr_data_q <= s_vtx_data;
              idx_q     <= idx_q + 1'b1;
              if (last_hs) begin
                loaded_q <= 1'b1;
                state_q  <= cfg_auto ? ST_START : ST_IDLE;
              end
            end
          end
          ST_START: begin
            err_timeout_q <= 1'b0;
            tmo_q         <= '0;
            state_q       <= ST_RENDER;
          end
          ST_RENDER: begin
            // frame_end wins if it lands on the same cycle as the timeout.
            if (fe_rise) begin
              state_q <= ST_DRAIN;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
              err_timeout_q <= 1'b1;
              state_q       <= ST_IDLE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (wr_idle) state_q <= ST_SWAP_WAIT;
          end
          ST_SWAP_WAIT: begin
            if (vsync) begin
              fb_q            <= disp_q;
              disp_q          <= fb_q;
              frame_done_q    <= 1'b1;
              frame_counter_q <= frame_counter_q + 16'd1;
              state_q         <= (cfg_auto && loaded_q) ? ST_START : ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_vtx_ready          = (state_q == ST_LOAD);
  assign gpu_start            = (state_q == ST_START) && !cmd_abort;
  assign busy                 = (state_q != ST_IDLE);
  assign mem_wr_en            = wr_en_q;
  assign mem_wr_addr          = wr_addr_q;
  assign mem_wr_data          = wr_data_q;
  assign vertex_count         = vertex_count_q;
  assign loaded               = loaded_q;
  assign err_count            = err_count_q;
  assign err_timeout          = err_timeout_q;
  assign framebuffer_baseaddr = fb_q;
  assign display_baseaddr     = disp_q;
  assign frame_done           = frame_done_q;
  assign frame_counter        = frame_counter_q;

endmodule

// File: tb/tb_gpu_frame_ctrl.sv
// Directed bench for gpu_frame_ctrl. Inputs change on the falling edge,
// outputs are compared on the falling edge. A second instance with a short
// timeout covers the render timeout path.
`timescale 1ns/1ps
module tb_gpu_frame_ctrl;
  localparam logic [31:0] FB0 = 32'h1000_0000;
  localparam logic [31:0] FB1 = 32'h1008_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cfg_vertex_count = '0;
  logic        cfg_auto = 1'b0, cmd_load = 1'b0, cmd_run = 1'b0, cmd_abort = 1'b0;
  logic [17:0] s_vtx_data = '0;
  logic        s_vtx_valid = 1'b0, gpu_frame_end = 1'b0, wr_idle = 1'b0, vsync = 1'b0;

  logic        s_vtx_ready, mem_wr_en, gpu_start, busy, loaded, frame_done, err_count, err_timeout;
  logic [13:0] mem_wr_addr;
  logic [17:0] mem_wr_data;
  logic [31:0] vertex_count, fb, disp;
  logic [15:0] frame_counter;

  logic        t_s_vtx_ready, t_mem_wr_en, t_gpu_start, t_busy, t_loaded, t_frame_done, t_err_count, t_err_timeout;
  logic [13:0] t_mem_wr_addr;
  logic [17:0] t_mem_wr_data;
  logic [31:0] t_vertex_count, t_fb, t_disp;
  logic [15:0] t_frame_counter;

  int n_tests = 0, n_fail = 0;
  int start_cnt = 0, wr_cnt = 0;
  logic [17:0] vd [4] = '{18'h0_1234, 18'h3_FFFF, 18'h2_0001, 18'h1_5A5A};

  always #5 clk = ~clk;

  gpu_frame_ctrl #(.M(11), .N(7), .VERTEX_MEM_DEPTH(16384), .FB_BASE0(FB0), .FB_BASE1(FB1),
                   .TIMEOUT_CYCLES(2000000)) dut (
    .clk(clk), .reset(reset), .cfg_vertex_count(cfg_vertex_count), .cfg_auto(cfg_auto),
    .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_abort(cmd_abort),
    .s_vtx_data(s_vtx_data), .s_vtx_valid(s_vtx_valid), .s_vtx_ready(s_vtx_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .vertex_count(vertex_count), .gpu_start(gpu_start), .gpu_frame_end(gpu_frame_end),
    .wr_idle(wr_idle), .vsync(vsync), .framebuffer_baseaddr(fb), .display_baseaddr(disp),
    .busy(busy), .loaded(loaded), .frame_done(frame_done), .frame_counter(frame_counter),
    .err_count(err_count), .err_timeout(err_timeout));

  gpu_frame_ctrl #(.M(11), .N(7), .VERTEX_MEM_DEPTH(16384), .FB_BASE0(FB0), .FB_BASE1(FB1),
                   .TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .reset(reset), .cfg_vertex_count(cfg_vertex_count), .cfg_auto(cfg_auto),
    .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_abort(cmd_abort),
    .s_vtx_data(s_vtx_data), .s_vtx_valid(s_vtx_valid), .s_vtx_ready(t_s_vtx_ready),
    .mem_wr_addr(t_mem_wr_addr), .mem_wr_data(t_mem_wr_data), .mem_wr_en(t_mem_wr_en),
    .vertex_count(t_vertex_count), .gpu_start(t_gpu_start), .gpu_frame_end(gpu_frame_end),
    .wr_idle(wr_idle), .vsync(vsync), .framebuffer_baseaddr(t_fb), .display_baseaddr(t_disp),
    .busy(t_busy), .loaded(t_loaded), .frame_done(t_frame_done), .frame_counter(t_frame_counter),
    .err_count(t_err_count), .err_timeout(t_err_timeout));

  // Count cycles with gpu_start / mem_wr_en high on the main instance.
  always @(negedge clk) begin
    #1;
    if (gpu_start === 1'b1) start_cnt++;
    if (mem_wr_en === 1'b1) wr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic load_words(input int n);
    cfg_vertex_count = n; cmd_load = 1'b1;
    @(negedge clk); cmd_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_vtx_valid = 1'b1; s_vtx_data = vd[i % 4];
      @(negedge clk);
    end
    s_vtx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, loaded, s_vtx_ready, mem_wr_en, gpu_start, frame_done, err_count, err_timeout} !== 8'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000000",
        {busy, loaded, s_vtx_ready, mem_wr_en, gpu_start, frame_done, err_count, err_timeout});
    end
    n_tests++;
    if (fb !== FB1 || disp !== FB0) begin
      n_fail++; $display("FAIL reset_base: got fb=%h disp=%h want fb=%h disp=%h", fb, disp, FB1, FB0);
    end
    n_tests++;
    if (frame_counter !== 16'd0 || vertex_count !== 32'd0 || mem_wr_addr !== 14'd0) begin
      n_fail++; $display("FAIL reset_counts: got fc=%0d vc=%0d addr=%0d want 0", frame_counter, vertex_count, mem_wr_addr);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_load();
    cfg_auto = 1'b0; cfg_vertex_count = 32'd4; cmd_load = 1'b1;
    @(negedge clk); cmd_load = 1'b0;
    n_tests++;
    if ({busy, s_vtx_ready, loaded} !== 3'b110 || vertex_count !== 32'd4) begin
      n_fail++; $display("FAIL load_enter: got busy/rdy/loaded=%b vc=%0d want 110 vc=4", {busy, s_vtx_ready, loaded}, vertex_count);
    end
    for (int i = 0; i < 4; i++) begin
      s_vtx_valid = 1'b1; s_vtx_data = vd[i];
      @(negedge clk);
      n_tests++;
      if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 14'(i), vd[i]}) begin
        n_fail++; $display("FAIL load_write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
          i, mem_wr_en, mem_wr_addr, mem_wr_data, i, vd[i]);
      end
    end
    n_tests++;
    if ({loaded, s_vtx_ready, busy} !== 3'b100) begin
      n_fail++; $display("FAIL load_done: got loaded/rdy/busy=%b want 100", {loaded, s_vtx_ready, busy});
    end
    s_vtx_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL load_extra_write: got en=%b want 0", mem_wr_en);
    end
  endtask

  task automatic test_count_err();
    int w0;
    w0 = wr_cnt;
    // Illegal load together with run: load wins, run is dropped.
    cfg_vertex_count = 32'd0; cmd_load = 1'b1; cmd_run = 1'b1;
    @(negedge clk); cmd_load = 1'b0; cmd_run = 1'b0;
    n_tests++;
    if ({err_count, busy, loaded, gpu_start} !== 4'b1010) begin
      n_fail++; $display("FAIL cnt_zero: got err/busy/loaded/start=%b want 1010", {err_count, busy, loaded, gpu_start});
    end
    cfg_vertex_count = 32'd16385; cmd_load = 1'b1;
    @(negedge clk); cmd_load = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({err_count, busy} !== 2'b10 || wr_cnt != w0) begin
      n_fail++; $display("FAIL cnt_over: got err/busy=%b writes=%0d want 10 writes=0", {err_count, busy}, wr_cnt - w0);
    end
    cfg_vertex_count = 32'd16384; cmd_load = 1'b1;
    @(negedge clk); cmd_load = 1'b0;
    n_tests++;
    if ({err_count, busy, loaded} !== 3'b010 || vertex_count !== 32'd16384) begin
      n_fail++; $display("FAIL cnt_max: got err/busy/loaded=%b vc=%0d want 010 vc=16384", {err_count, busy, loaded}, vertex_count);
    end
    cmd_abort = 1'b1;
    @(negedge clk); cmd_abort = 1'b0;
    n_tests++;
    if ({busy, loaded, s_vtx_ready} !== 3'b000) begin
      n_fail++; $display("FAIL cnt_abort: got busy/loaded/rdy=%b want 000", {busy, loaded, s_vtx_ready});
    end
  endtask

  task automatic test_frame();
    int s0;
    s0 = start_cnt;
    cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
    n_tests++;
    if ({gpu_start, busy} !== 2'b11) begin
      n_fail++; $display("FAIL frame_start: got start/busy=%b want 11", {gpu_start, busy});
    end
    @(negedge clk);
    n_tests++;
    if ({gpu_start, err_timeout} !== 2'b00) begin
      n_fail++; $display("FAIL frame_start_len: got start/errto=%b want 00", {gpu_start, err_timeout});
    end
    repeat (98) @(negedge clk);
    gpu_frame_end = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    // vsync in the DRAIN->SWAP_WAIT transition cycle must be ignored.
    vsync = 1'b1; wr_idle = 1'b1;
    @(negedge clk); vsync = 1'b0; gpu_frame_end = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({frame_done, busy} !== 2'b01 || frame_counter !== 16'd0 || fb !== FB1) begin
      n_fail++; $display("FAIL frame_early_vsync: got done/busy=%b fc=%0d fb=%h want 01 fc=0 fb=%h",
        {frame_done, busy}, frame_counter, fb, FB1);
    end
    repeat (48) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    n_tests++;
    if ({frame_done, busy} !== 2'b10 || fb !== FB0 || disp !== FB1 || frame_counter !== 16'd1) begin
      n_fail++; $display("FAIL frame_swap: got done/busy=%b fb=%h disp=%h fc=%0d want 10 fb=%h disp=%h fc=1",
        {frame_done, busy}, fb, disp, frame_counter, FB0, FB1);
    end
    @(negedge clk);
    n_tests++;
    if (frame_done !== 1'b0 || start_cnt - s0 != 1) begin
      n_fail++; $display("FAIL frame_pulses: got done=%b starts=%0d want done=0 starts=1", frame_done, start_cnt - s0);
    end
  endtask

  task automatic test_auto();
    int s0, w0;
    logic [31:0] efb [3];
    logic [31:0] edisp [3];
    efb = '{FB1, FB0, FB1};
    edisp = '{FB0, FB1, FB0};
    s0 = start_cnt; w0 = wr_cnt;
    cfg_auto = 1'b1; cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 10 && gpu_start !== 1'b1; k++) @(negedge clk);
      n_tests++;
      if (gpu_start !== 1'b1) begin
        n_fail++; $display("FAIL auto_start%0d: got start=%b want 1 within 10 cycles", f, gpu_start);
      end
      repeat (5) @(negedge clk);
      gpu_frame_end = 1'b1;
      @(negedge clk); gpu_frame_end = 1'b0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      if (f == 2) cfg_auto = 1'b0;
      vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
      n_tests++;
      if (frame_done !== 1'b1 || fb !== efb[f] || disp !== edisp[f] || frame_counter !== 16'(2 + f)) begin
        n_fail++; $display("FAIL auto_swap%0d: got done=%b fb=%h disp=%h fc=%0d want done=1 fb=%h disp=%h fc=%0d",
          f, frame_done, fb, disp, frame_counter, efb[f], edisp[f], 2 + f);
      end
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || loaded !== 1'b1 || start_cnt - s0 != 3 || wr_cnt != w0) begin
      n_fail++; $display("FAIL auto_end: got busy=%b loaded=%b starts=%0d writes=%0d want 0 1 3 0",
        busy, loaded, start_cnt - s0, wr_cnt - w0);
    end
  endtask

  task automatic test_abort_load();
    cfg_vertex_count = 32'd4; cmd_load = 1'b1;
    @(negedge clk); cmd_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_vtx_valid = 1'b1; s_vtx_data = vd[i];
      @(negedge clk);
    end
    // Third word offered in the abort cycle must not be written.
    cmd_abort = 1'b1; s_vtx_data = vd[2];
    n_tests++;
    if (s_vtx_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_rdy_before: got rdy=%b want 1", s_vtx_ready);
    end
    @(negedge clk); cmd_abort = 1'b0; s_vtx_valid = 1'b0;
    n_tests++;
    if ({s_vtx_ready, busy, loaded, mem_wr_en} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_load: got rdy/busy/loaded/en=%b want 0000", {s_vtx_ready, busy, loaded, mem_wr_en});
    end
    cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
    n_tests++;
    if ({busy, gpu_start} !== 2'b00) begin
      n_fail++; $display("FAIL abort_run_unloaded: got busy/start=%b want 00", {busy, gpu_start});
    end
  endtask

  task automatic test_reset_mid_render();
    load_words(4);
    cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || loaded !== 1'b1 || frame_counter !== 16'd4) begin
      n_fail++; $display("FAIL rst_pre: got busy=%b loaded=%b fc=%0d want 1 1 4", busy, loaded, frame_counter);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, loaded, gpu_start} !== 3'b000 || frame_counter !== 16'd0 || vertex_count !== 32'd0 ||
        fb !== FB1 || disp !== FB0) begin
      n_fail++; $display("FAIL rst_async: got busy/loaded/start=%b fc=%0d vc=%0d fb=%h disp=%h want 000 0 0 %h %h",
        {busy, loaded, gpu_start}, frame_counter, vertex_count, fb, disp, FB1, FB0);
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    load_words(4);
    cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
    n_tests++;
    if ({t_gpu_start, t_err_timeout} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_start: got start/errto=%b want 10", {t_gpu_start, t_err_timeout});
    end
    // err_timeout rises on the edge closing the 50th RENDER cycle.
    repeat (50) @(negedge clk);
    n_tests++;
    if ({t_err_timeout, t_busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_early: got errto/busy=%b want 01", {t_err_timeout, t_busy});
    end
    @(negedge clk);
    n_tests++;
    if ({t_err_timeout, t_busy, t_frame_done} !== 3'b100 || t_fb !== FB1 || t_disp !== FB0 || t_frame_counter !== 16'd0) begin
      n_fail++; $display("FAIL tmo_fire: got errto/busy/done=%b fb=%h disp=%h fc=%0d want 100 %h %h 0",
        {t_err_timeout, t_busy, t_frame_done}, t_fb, t_disp, t_frame_counter, FB1, FB0);
    end
    cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({t_err_timeout, t_busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_clear: got errto/busy=%b want 01", {t_err_timeout, t_busy});
    end
    cmd_abort = 1'b1;
    @(negedge clk); cmd_abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_count_err();
    load_words(4);
    test_frame();
    test_auto();
    test_abort_load();
    test_reset_mid_render();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
